// File: rtl/sobel_dma_ctrl.sv
// Sobel result DMA: FIFO-buffered burst writer, configured over the CI port.
// Optional cycle-stall counter: define SOBEL_DMA_PERF_EN.
module sobel_dma_ctrl #(
  parameter logic [7:0] customId = 8'd0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        pixelValid,
  input  logic [31:0] pixelWord,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        requestBus,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        endTransactionOut,
  output logic [3:0]  byteEnablesOut,
  output logic        dataValidOut,
  output logic [7:0]  burstSizeOut,
  input  logic        busyIn,
  input  logic        busErrorIn
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_BEGIN = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  logic [2:0]    state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic        running;
  logic        overflow;
  logic        error;
  logic        frame_done;
  logic        frame_pending;
  logic        vsync_q;
  logic        abort;
  logic [31:0] base_addr;
  logic [31:0] wr_addr;
  logic [8:0]  burst_len;
  logic [8:0]  burst_n;
  logic [8:0]  beats;
  logic [23:0] frame_words;
  logic [23:0] remaining;

  logic        full;
  logic        limit;
  logic [8:0]  n_calc;
  logic        start;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        flush;
  logic        ci_hit;
  logic [2:0]  op;
  logic [8:0]  bl_clamp;
  logic [8:0]  bl_raw;
  logic [7:0]  cnt8;
  logic [31:0] status;
  logic [31:0] ci_data;
  logic [31:0] perf_val;
  logic        bus_err;
  logic        unused_bits;

  assign unused_bits = ^{ciValueA[31:3], ciValueB[31:24]};

  assign full     = count == CW'(FIFO_DEPTH);
  assign limit    = frame_words != 24'd0;
  assign push_req = pixelValid && running;
  assign push     = push_req && !full;
  assign pop      = (state == S_DATA) && !busyIn && !busErrorIn;
  assign flush    = (state == S_IDLE) && frame_pending;
  assign ci_hit   = ciStart && (ciN == customId);
  assign op       = ciValueA[2:0];
  assign cnt8     = 8'(count);
  assign bus_err  = busErrorIn &&
                    ((state == S_BEGIN) || (state == S_DATA));

  always_comb begin
    n_calc = burst_len;
    if (limit && ({15'd0, burst_len} > remaining))
      n_calc = remaining[8:0];
  end

  // A zero-length burst is never started (burstLen is 0 out of reset).
  assign start = (state == S_IDLE) && running &&
                 !frame_pending && (n_calc != 9'd0) &&
                 (9'(count) >= n_calc) &&
                 (!limit || remaining != 24'd0);

  always_comb begin
    bl_raw   = {1'b0, ciValueB[7:0]};
    bl_clamp = bl_raw;
    if (bl_raw == 9'd0)
      bl_clamp = 9'd1;
    else if (bl_raw > 9'(FIFO_DEPTH))
      bl_clamp = 9'(FIFO_DEPTH);
  end

  assign status = {16'd0, cnt8, 4'd0,
                   overflow, error, frame_done, running};

  always_comb begin
    ci_data = 32'd0;
    case (op)
      3'd0:    ci_data = status;
      3'd6:    ci_data = perf_val;
      default: ci_data = 32'd0;
    endcase
  end

`ifdef SOBEL_DMA_PERF_EN
  logic [31:0] perf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      perf <= 32'd0;
    else if (ci_hit && op == 3'd4)
      perf <= 32'd0;
    else if (((state == S_REQ) ||
              (state == S_DATA && busyIn)) &&
             perf != 32'hFFFF_FFFF)
      perf <= perf + 32'd1;
  end

  assign perf_val = perf;
`else
  assign perf_val = 32'd0;
`endif

  always_ff @(posedge clock) begin
    if (push)
      mem[wptr] <= pixelWord;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ciDone        <= 1'b0;
      ciResult      <= 32'd0;
      running       <= 1'b0;
      overflow      <= 1'b0;
      error         <= 1'b0;
      frame_done    <= 1'b0;
      frame_pending <= 1'b0;
      vsync_q       <= 1'b0;
      abort         <= 1'b0;
      base_addr     <= 32'd0;
      wr_addr       <= 32'd0;
      burst_len     <= 9'd0;
      burst_n       <= 9'd0;
      beats         <= 9'd0;
      frame_words   <= 24'd0;
      remaining     <= 24'd0;
      state         <= S_IDLE;
    end else begin
      ciDone   <= ci_hit;
      ciResult <= ci_hit ? ci_data : 32'd0;
      vsync_q  <= vsync;

      if (ci_hit) begin
        case (op)
          3'd1: base_addr <= {ciValueB[31:2], 2'b00};
          3'd2: burst_len <= bl_clamp;
          3'd3: frame_words <= ciValueB[23:0];
          3'd4: begin
            running    <= 1'b1;
            overflow   <= 1'b0;
            error      <= 1'b0;
            frame_done <= 1'b0;
          end
          3'd5: running <= 1'b0;
          default: ;
        endcase
      end

      if (push_req && full)
        overflow <= 1'b1;

      if (flush) begin
        wr_addr       <= base_addr;
        remaining     <= frame_words;
        frame_done    <= 1'b0;
        frame_pending <= 1'b0;
      end
      if (vsync && !vsync_q && running)
        frame_pending <= 1'b1;

      if (bus_err) begin
        error   <= 1'b1;
        running <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            burst_n <= n_calc;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (busGrant)
            state <= S_BEGIN;
        end
        S_BEGIN: begin
          beats <= 9'd0;
          if (busErrorIn) begin
            abort <= 1'b1;
            state <= S_END;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (busErrorIn) begin
            abort <= 1'b1;
            state <= S_END;
          end else if (pop) begin
            beats <= beats + 9'd1;
            if (beats + 9'd1 == burst_n)
              state <= S_END;
          end
        end
        S_END: begin
          // An aborted burst leaves address and frame budget untouched.
          if (!abort) begin
            wr_addr <= wr_addr + {21'd0, burst_n, 2'b00};
            if (limit) begin
              remaining <= remaining - {15'd0, burst_n};
              if (remaining == {15'd0, burst_n})
                frame_done <= 1'b1;
            end
          end
          abort <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    requestBus          = 1'b0;
    beginTransactionOut = 1'b0;
    endTransactionOut   = 1'b0;
    dataValidOut        = 1'b0;
    addressDataOut      = 32'd0;
    byteEnablesOut      = 4'h0;
    burstSizeOut        = 8'd0;
    unique case (state)
      S_REQ: requestBus = 1'b1;
      S_BEGIN: begin
        requestBus          = 1'b1;
        beginTransactionOut = 1'b1;
        addressDataOut      = wr_addr;
        byteEnablesOut      = 4'hF;
        burstSizeOut        = 8'(burst_n - 9'd1);
      end
      S_DATA: begin
        requestBus     = 1'b1;
        dataValidOut   = 1'b1;
        addressDataOut = mem[rptr];
        byteEnablesOut = 4'hF;
      end
      S_END: endTransactionOut = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/sobel_dma_ctrl.md
Name: sobel_dma_ctrl

Overview:
Bus-master write controller that sequences the Sobel filter's output stream into main memory. It buffers 32-bit packed result words in an internal FIFO and issues burst writes on the shared bus once enough words are queued. It is configured and polled by the CPU through the custom-instruction interface. It sits between the Sobel datapath output and the bus arbiter, one instance per camera pipeline.

Parameters:
customId, 8'd0, custom-instruction ID this block answers to.
FIFO_DEPTH, 16, result FIFO depth in 32-bit words; power of two, 2..256.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
vsync  in  1  camera frame sync; a rising edge marks a new frame
pixelValid  in  1  pixelWord is valid this cycle
pixelWord  in  32  packed Sobel result word
ciStart  in  1  custom-instruction strobe
ciN  in  8  custom-instruction ID
ciValueA  in  32  opcode in bits [2:0]
ciValueB  in  32  operand
ciResult  out  32  read data
ciDone  out  1  instruction complete
requestBus  out  1  bus request
busGrant  in  1  bus granted
beginTransactionOut  out  1  transaction start strobe
addressDataOut  out  32  address during begin, data during beats
endTransactionOut  out  1  transaction end strobe
byteEnablesOut  out  4  byte enables
dataValidOut  out  1  data beat valid
burstSizeOut  out  8  beats minus 1
busyIn  in  1  slave stall
busErrorIn  in  1  bus error

Behaviour:
- Reset clears all registers, the FIFO and sticky flags. Every output is 0 at reset.
- CI handling:
  - An instruction is accepted when ciStart=1 and ciN==customId.
  - ciDone pulses 1 cycle on the next clock edge.
  - ciResult holds its value only while ciDone=1 and is 0 otherwise.
- Opcodes:
  - 0: read status. Returns {fifoCount[15:8], 4'b0, overflow, error, frameDone, running} in [15:0]; bits [31:16] are 0.
  - 1: set baseAddr = ciValueB, forced word-aligned by zeroing [1:0].
  - 2: set burstLen = ciValueB[7:0], clamped to the range 1..FIFO_DEPTH.
  - 3: set frameWords = ciValueB[23:0]. 0 means no limit.
  - 4: set running=1 and clear the sticky flags.
  - 5: set running=0. Any burst in flight completes first.
  - 6: performance counter (see Optional Feature).
  - 7: no operation; returns 0.
- FIFO:
  - When pixelValid=1 and running=1, pixelWord is written.
  - A write while full drops the word and sets overflow (sticky).
  - Writes are ignored while running=0.
  - Simultaneous push and pop keeps the count unchanged.
- Frame handling:
  - A rising edge of vsync while running sets framePending.
  - framePending is applied only in IDLE. Applying it flushes the FIFO, sets wrAddr=baseAddr, sets remaining=frameWords, clears frameDone, and clears framePending.
- State machine (IDLE, REQ, BEGIN, DATA, END):
  - IDLE -> REQ when running=1, framePending=0, and fifoCount >= n, where n = min(burstLen, remaining) when frameWords≠0, otherwise n = burstLen. Also requires remaining>0 when frameWords≠0.
  - REQ: requestBus=1. Move to BEGIN on busGrant.
  - BEGIN: one cycle. beginTransactionOut=1, addressDataOut=wrAddr, burstSizeOut=n-1, byteEnablesOut=4'hF.
  - DATA: dataValidOut=1 and addressDataOut=FIFO head. The FIFO pops only when busyIn=0; busyIn=1 holds the same word. After the n-th accepted beat, go to END.
  - END: one cycle. endTransactionOut=1. Then wrAddr += 4n and remaining -= n.
  - END -> IDLE. If remaining reaches 0, set frameDone (sticky).
  - requestBus stays high from REQ through DATA and drops in END.
- Bus error: busErrorIn in BEGIN or DATA forces END on the next cycle, sets error (sticky) and sets running=0. Unsent FIFO words are retained.
- Bus output hygiene: all bus outputs other than requestBus are 0 outside BEGIN, DATA and END.
- Reset mid-burst: the machine returns to IDLE immediately, without an endTransactionOut.

Optional Feature:
SOBEL_DMA_PERF_EN
- Defined:
  - A 32-bit counter increments each cycle spent in REQ, or in DATA with busyIn=1.
  - Opcode 6 returns the counter.
  - Opcode 4 clears the counter.
  - The counter saturates at 32'hFFFFFFFF.
- Undefined: no counter logic; opcode 6 returns 0.

Test Plan:
- CI config with customId=0: write base 0x1000_0003 and burstLen 4, then read status -> base latches as 0x1000_0000, each ciDone is 1 cycle, status=0x0000.
- Start, vsync edge, push 4 words A0..A3 -> requestBus. Grant -> begin with addr 0x1000_0000, burstSize 3, BE F. Beats A0..A3, then end. Next burst targets 0x1000_0010.
- busyIn high for 3 cycles during beat 2 -> the same word is held on addressDataOut, total beats still 4, no words lost.
- frameWords=6, burstLen=4, push 6 words -> bursts of 4 then 2 (burstSize 1); frameDone=1, status bit1 set.
- Push 17 words with no grant, FIFO_DEPTH=16 -> overflow set, fifoCount=16, the 17th word is absent from later bursts.
- busErrorIn asserted on beat 1 -> END next cycle, error=1, running=0, no new request after END.
